// File: rtl/memory_bus_responder_if.sv
// Memory bus bundle between the CPU-side bus interface and the write responder.
// The WR_CNT member exists only when MEMORY_BUS_WR_COUNTER_EN is defined.
interface memory_bus_responder_if;
    logic        EN;
    logic        WE;
    logic [1:0]  BRAM_SELECT;
    logic [13:0] BRAM_ADDR;
    logic [15:0] DATA_IN;
    logic [15:0] WR_DATA;
    logic        CTL_WE;
    logic [12:0] CTL_ADDR;
    logic        DUTY_WE;
    logic [14:0] DUTY_ADDR;
    logic        MOD_WE;
    logic [14:0] MOD_ADDR;
    logic        NORMAL_WE;
    logic [8:0]  NORMAL_ADDR;
    logic        STM_WE;
    logic [18:0] STM_ADDR;
`ifdef MEMORY_BUS_WR_COUNTER_EN
    logic [15:0] WR_CNT;
`endif

    modport slave (
        input  EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN,
        output WR_DATA, CTL_WE, CTL_ADDR, DUTY_WE, DUTY_ADDR, MOD_WE, MOD_ADDR,
               NORMAL_WE, NORMAL_ADDR, STM_WE, STM_ADDR
`ifdef MEMORY_BUS_WR_COUNTER_EN
        , WR_CNT
`endif
    );

    modport master (
        output EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN,
        input  WR_DATA, CTL_WE, CTL_ADDR, DUTY_WE, DUTY_ADDR, MOD_WE, MOD_ADDR,
               NORMAL_WE, NORMAL_ADDR, STM_WE, STM_ADDR
`ifdef MEMORY_BUS_WR_COUNTER_EN
        , WR_CNT
`endif
    );
endinterface

// File: rtl/memory_bus_responder.sv
// Turns each CPU bus write transaction into one single-cycle strobe toward one target.
// Optional write counter output WR_CNT is enabled by defining MEMORY_BUS_WR_COUNTER_EN.
module memory_bus_responder #(
    parameter logic [13:0] ADDR_DUTY_TABLE_WR_PAGE = 14'h0010,
    parameter logic [13:0] ADDR_MOD_MEM_WR_SEGMENT = 14'h0011,
    parameter logic [13:0] ADDR_STM_MEM_WR_SEGMENT = 14'h0012,
    parameter logic [13:0] ADDR_STM_MEM_WR_PAGE    = 14'h0013
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    memory_bus_responder_if.slave bus
);
    logic        req_q;
    logic        prev_req;
    logic [1:0]  sel_q;
    logic [13:0] addr_q;
    logic [15:0] data_q;
    logic [1:0]  duty_page;
    logic        mod_segment;
    logic        stm_segment;
    logic [3:0]  stm_page;
    logic        wr_event;
    logic        ctl_event;

    assign wr_event  = req_q & ~prev_req;
    assign ctl_event = wr_event && (sel_q == 2'd0) && !addr_q[13];

    // req_q and prev_req both reset high so a write held across reset release is ignored
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q           <= 1'b1;
            prev_req        <= 1'b1;
            sel_q           <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            duty_page       <= '0;
            mod_segment     <= 1'b0;
            stm_segment     <= 1'b0;
            stm_page        <= '0;
            bus.WR_DATA     <= '0;
            bus.CTL_WE      <= 1'b0;
            bus.CTL_ADDR    <= '0;
            bus.DUTY_WE     <= 1'b0;
            bus.DUTY_ADDR   <= '0;
            bus.MOD_WE      <= 1'b0;
            bus.MOD_ADDR    <= '0;
            bus.NORMAL_WE   <= 1'b0;
            bus.NORMAL_ADDR <= '0;
            bus.STM_WE      <= 1'b0;
            bus.STM_ADDR    <= '0;
`ifdef MEMORY_BUS_WR_COUNTER_EN
            bus.WR_CNT      <= '0;
`endif
        end else begin
            req_q    <= bus.EN & bus.WE;
            sel_q    <= bus.BRAM_SELECT;
            addr_q   <= bus.BRAM_ADDR;
            data_q   <= bus.DATA_IN;
            prev_req <= req_q;

            bus.CTL_WE    <= ctl_event;
            bus.DUTY_WE   <= wr_event && (sel_q == 2'd0) && addr_q[13];
            bus.MOD_WE    <= wr_event && (sel_q == 2'd1);
            bus.NORMAL_WE <= wr_event && (sel_q == 2'd2);
            bus.STM_WE    <= wr_event && (sel_q == 2'd3);

            if (wr_event) begin
                bus.WR_DATA     <= data_q;
                bus.CTL_ADDR    <= addr_q[12:0];
                bus.DUTY_ADDR   <= {duty_page, addr_q[12:0]};
                bus.MOD_ADDR    <= {mod_segment, addr_q};
                bus.NORMAL_ADDR <= addr_q[8:0];
                bus.STM_ADDR    <= {stm_segment, stm_page, addr_q};
`ifdef MEMORY_BUS_WR_COUNTER_EN
                bus.WR_CNT      <= bus.WR_CNT + 16'd1;
`endif
            end

            // page/segment registers take effect for the next transaction
            if (ctl_event) begin
                if (addr_q == ADDR_DUTY_TABLE_WR_PAGE) duty_page   <= data_q[1:0];
                if (addr_q == ADDR_MOD_MEM_WR_SEGMENT) mod_segment <= data_q[0];
                if (addr_q == ADDR_STM_MEM_WR_SEGMENT) stm_segment <= data_q[0];
                if (addr_q == ADDR_STM_MEM_WR_PAGE)    stm_page    <= data_q[3:0];
            end
        end
    end
endmodule
